lsu_pipe: RTL and testbench

Parametrised load/store unit for the 8-bit CPU core. It pipelines data-memory reads and writes into a local synchronous RAM and a bank of memory-mapped output port registers. It also owns the hardware stack pointer, with push, pop and load operations that use the same RAM port. It sits between the execute stage and data memory, and adds a fixed-latency read pipeline and fault reporting.

---
 rtl/lsu_pipe.sv | 242 ++++++++++++++++++++++++
 tb/tb_lsu_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_pipe.sv
// -----------------------------------------------------------------------------
// lsu_pipe - load/store unit for the 8-bit CPU core
//
// Pipelines data-memory reads and writes into a local synchronous RAM and a
// bank of memory-mapped output port registers, and owns the hardware stack
// pointer (PUSH / POP / LOAD share the single RAM port with normal accesses).
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_req      access request (ignored while a stack op is presented)
//   i_we       1 = write, 0 = read
//   i_addr     access address, or new SP value for SP LOAD
//   i_wdata    write data / push data
//   i_sp_op    00 NOP, 01 PUSH, 10 POP, 11 LOAD
//   o_ready    combinational: request will be accepted this cycle
//   o_rvalid   read data valid (two edges after acceptance)
//   o_rdata    read data
//   o_sp       current stack pointer
//   o_port_q   flattened output port registers, port i at [i*DATA_W +: DATA_W]
//   o_fault    one-cycle fault pulse
//
// Configuration macro: LSU_STACK_GUARD_EN
//   defined   - PUSH at STACK_LIMIT and POP at STACK_TOP are blocked and fault
//   undefined - SP wraps modulo 2^ADDR_W, RAM index wraps modulo RAM_DEPTH
// -----------------------------------------------------------------------------
module lsu_pipe #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 16,
  parameter int                RAM_DEPTH   = 256,
  parameter logic [ADDR_W-1:0] IO_BASE     = 16'h4000,
  parameter int                NUM_PORTS   = 3,
  parameter int                STACK_TOP   = RAM_DEPTH,
  parameter int                STACK_LIMIT = 0
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_req,
  input  logic                          i_we,
  input  logic [ADDR_W-1:0]             i_addr,
  input  logic [DATA_W-1:0]             i_wdata,
  input  logic [1:0]                    i_sp_op,
  output logic                          o_ready,
  output logic                          o_rvalid,
  output logic [DATA_W-1:0]             o_rdata,
  output logic [ADDR_W-1:0]             o_sp,
  output logic [NUM_PORTS*DATA_W-1:0]   o_port_q,
  output logic                          o_fault
);

  localparam int RA_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int PI_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] SP_NOP  = 2'b00;
  localparam logic [1:0] SP_PUSH = 2'b01;
  localparam logic [1:0] SP_POP  = 2'b10;
  localparam logic [1:0] SP_LOAD = 2'b11;

  localparam logic [ADDR_W-1:0] SP_TOP = ADDR_W'(STACK_TOP);
  localparam logic [ADDR_W-1:0] SP_LIM = ADDR_W'(STACK_LIMIT);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

  // storage
  logic [DATA_W-1:0] r_mem [RAM_DEPTH];
  logic [DATA_W-1:0] r_ram_q;
  logic [DATA_W-1:0] r_port [NUM_PORTS];
  logic [ADDR_W-1:0] r_sp;

  // read pipeline stage 1 (captured at acceptance)
  logic              r_s1_valid;
  logic [RA_W-1:0]   r_s1_idx;
  logic              r_s1_ram;
  logic              r_s1_bad;
  logic [DATA_W-1:0] r_s1_pdata;
  // read pipeline stage 2 (RAM array sampled into r_ram_q alongside)
  logic              r_s2_valid;
  logic              r_s2_ram;
  logic              r_s2_bad;
  logic [DATA_W-1:0] r_s2_pdata;
  // output registers
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_fault;

  // decode / control
  logic              w_ready;
  logic              w_in_ram;
  logic              w_in_port;
  logic [ADDR_W-1:0] w_port_off;
  logic [PI_W-1:0]   w_port_idx;
  logic [DATA_W-1:0] w_port_rd;
  logic              w_acc_wr;
  logic              w_acc_rd;
  logic              w_push;
  logic              w_pop;
  logic              w_load;
  logic              w_push_blk;
  logic              w_pop_blk;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic [ADDR_W-1:0] w_sp_dec;
  logic [ADDR_W-1:0] w_sp_inc;
  logic              w_ram_we;
  logic [RA_W-1:0]   w_ram_widx;
  logic              w_s1_launch;
  logic              w_fault_now;

  // Address decode, stack-op qualification and RAM port arbitration
  always_comb begin
    w_ready    = i_rst_n && (i_sp_op == SP_NOP);
    // in RAM when no address bits above the RAM index are set
    w_in_ram   = ((i_addr >> RA_W) == {ADDR_W{1'b0}});
    w_port_off = i_addr - IO_BASE;
    w_in_port  = (i_addr >= IO_BASE) && (w_port_off < ADDR_W'(NUM_PORTS));
    w_port_idx = w_port_off[PI_W-1:0];

    w_acc_wr   = i_req && i_we && w_ready;
    w_acc_rd   = i_req && !i_we && w_ready;

    w_push     = i_rst_n && (i_sp_op == SP_PUSH);
    w_pop      = i_rst_n && (i_sp_op == SP_POP);
    w_load     = i_rst_n && (i_sp_op == SP_LOAD);
`ifdef LSU_STACK_GUARD_EN
    w_push_blk = w_push && (r_sp == SP_LIM);
    w_pop_blk  = w_pop && (r_sp == SP_TOP);
`else
    w_push_blk = 1'b0;
    w_pop_blk  = 1'b0;
`endif
    w_push_ok  = w_push && !w_push_blk;
    w_pop_ok   = w_pop && !w_pop_blk;

    w_sp_dec   = r_sp - ONE_A;
    w_sp_inc   = r_sp + ONE_A;

    w_ram_we   = (w_acc_wr && w_in_ram) || w_push_ok;
    if (w_push_ok) begin
      w_ram_widx = w_sp_dec[RA_W-1:0];
    end else begin
      w_ram_widx = i_addr[RA_W-1:0];
    end

    w_s1_launch = w_acc_rd || w_pop_ok;
    w_fault_now = (w_acc_wr && !w_in_ram && !w_in_port) || w_push_blk || w_pop_blk;
  end

  // Port register readback mux (zero when the address is not a port)
  always_comb begin
    w_port_rd = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_in_port && (w_port_idx == PI_W'(i))) begin
        w_port_rd = r_port[i];
      end else begin
        w_port_rd = w_port_rd;
      end
    end
  end

  // RAM array: write port plus synchronous read of the stage-1 index.
  // The read is one edge after acceptance, so a write on that same edge is
  // ordered after the read (old data), and a write on the acceptance edge or
  // earlier is seen.
  always_ff @(posedge i_clk) begin
    if (w_ram_we) begin
      r_mem[w_ram_widx] <= i_wdata;
    end
    r_ram_q <= r_mem[r_s1_idx];
  end

  // Stack pointer and output port registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sp <= SP_TOP;
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_port[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (w_push_ok) begin
        r_sp <= w_sp_dec;
      end else if (w_pop_ok) begin
        r_sp <= w_sp_inc;
      end else if (w_load) begin
        r_sp <= i_addr;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_acc_wr && w_in_port && (w_port_idx == PI_W'(i))) begin
          r_port[i] <= i_wdata;
        end
      end
    end
  end

  // Read pipeline stages, output registers and fault pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_idx   <= {RA_W{1'b0}};
      r_s1_ram   <= 1'b0;
      r_s1_bad   <= 1'b0;
      r_s1_pdata <= {DATA_W{1'b0}};
      r_s2_valid <= 1'b0;
      r_s2_ram   <= 1'b0;
      r_s2_bad   <= 1'b0;
      r_s2_pdata <= {DATA_W{1'b0}};
      r_rvalid   <= 1'b0;
      r_rdata    <= {DATA_W{1'b0}};
      r_fault    <= 1'b0;
    end else begin
      r_s1_valid <= w_s1_launch;
      if (w_s1_launch) begin
        // POP reads mem[sp mod RAM_DEPTH]; plain reads use the address
        r_s1_idx   <= w_pop_ok ? r_sp[RA_W-1:0] : i_addr[RA_W-1:0];
        r_s1_ram   <= w_pop_ok || w_in_ram;
        r_s1_bad   <= !w_pop_ok && !w_in_ram && !w_in_port;
        r_s1_pdata <= w_port_rd;
      end

      r_s2_valid <= r_s1_valid;
      r_s2_ram   <= r_s1_ram;
      r_s2_bad   <= r_s1_bad;
      r_s2_pdata <= r_s1_pdata;

      r_rvalid <= r_s2_valid;
      if (r_s2_valid) begin
        r_rdata <= r_s2_ram ? r_ram_q : r_s2_pdata;
      end
      // a faulting read flags alongside its rvalid; others flag immediately
      r_fault <= w_fault_now || (r_s2_valid && r_s2_bad);
    end
  end

  assign o_ready  = w_ready;
  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;
  assign o_sp     = r_sp;
  assign o_fault  = r_fault;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port_out
    assign o_port_q[g*DATA_W +: DATA_W] = r_port[g];
  end

endmodule

// File: tb/tb_lsu_pipe.sv
module tb_lsu_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic [1:0]  sp_op = 2'b00;
  logic        ready;
  logic        rvalid;
  logic [7:0]  rdata;
  logic [15:0] sp;
  logic [23:0] port_q;
  logic        fault;

  lsu_pipe dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_req    (req),
    .i_we     (we),
    .i_addr   (addr),
    .i_wdata  (wdata),
    .i_sp_op  (sp_op),
    .o_ready  (ready),
    .o_rvalid (rvalid),
    .o_rdata  (rdata),
    .o_sp     (sp),
    .o_port_q (port_q),
    .o_fault  (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       flt;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic pend_fault = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic unmapped(input logic [15:0] a);
    return !((a < 16'd256) || ((a >= 16'h4000) && (a <= 16'h4002)));
  endfunction

  // one clock; sample 1 time unit after the edge and check the scoreboard
  task automatic tick();
    exp_t e;
    logic exp_f;
    @(posedge clk);
    cyc++;
    #1;
    exp_f = pend_fault;
    pend_fault = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("rvalid", {31'd0, rvalid}, 32'd1);
      check("rdata", {24'd0, rdata}, {24'd0, e.data});
      exp_f = exp_f | e.flt;
    end else begin
      check("rvalid_idle", {31'd0, rvalid}, 32'd0);
    end
    check("fault", {31'd0, fault}, {31'd0, exp_f});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d; sp_op = 2'b00;
    pend_fault = unmapped(a);
    tick();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] d, input logic f);
    req = 1'b1; we = 1'b0; addr = a; sp_op = 2'b00;
    sb.push_back('{data: d, flt: f, due: cyc + 3});
    tick();
    req = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    sp_op = 2'b01; wdata = d;
    tick();
    sp_op = 2'b00;
  endtask

  task automatic pop(input logic [7:0] d);
    sp_op = 2'b10;
    sb.push_back('{data: d, flt: 1'b0, due: cyc + 3});
    tick();
    sp_op = 2'b00;
  endtask

  task automatic load(input logic [15:0] a);
    sp_op = 2'b11; addr = a;
    tick();
    sp_op = 2'b00;
  endtask

  initial begin
    // reset state
    idle(2);
    check("ready_in_reset", {31'd0, ready}, 32'd0);
    check("sp_reset", {16'd0, sp}, 32'd256);
    check("port_reset", {8'd0, port_q}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_idle", {31'd0, ready}, 32'd1);
    idle(1);

    // RAM write then read back, latency two
    wr(16'h0000, 8'd100);
    rd(16'h0000, 8'd100, 1'b0);
    idle(3);

    // port write and readback, last port, unmapped just past port region
    wr(16'h4001, 8'd48);
    check("port1", {24'd0, port_q[15:8]}, 32'd48);
    rd(16'h4001, 8'd48, 1'b0);
    wr(16'h4002, 8'h5C);
    wr(16'h4003, 8'hEE);
    check("ports_after_bad_wr", {8'd0, port_q}, 32'h5C3000);
    rd(16'h4002, 8'h5C, 1'b0);
    idle(3);

    // unmapped read: zero data with fault alongside rvalid
    rd(16'h8000, 8'h00, 1'b1);
    idle(3);
    // unmapped write faults and changes nothing
    wr(16'h8000, 8'h77);
    check("ports_after_8000", {8'd0, port_q}, 32'h5C3000);

    // back-to-back reads of RAM (top index) and port
    wr(16'h00FF, 8'h3C);
    rd(16'h00FF, 8'h3C, 1'b0);
    rd(16'h4001, 8'd48, 1'b0);
    rd(16'h0000, 8'd100, 1'b0);
    idle(3);

    // stack push/pop
    push(8'hAA);
    push(8'hBB);
    check("sp_after_push", {16'd0, sp}, 32'd254);
    pop(8'hBB);
    pop(8'hAA);
    check("sp_after_pop", {16'd0, sp}, 32'd256);
    idle(3);

    // POP on empty stack
`ifdef LSU_STACK_GUARD_EN
    sp_op = 2'b10;
    pend_fault = 1'b1;
    tick();
    sp_op = 2'b00;
    check("sp_guard_pop", {16'd0, sp}, 32'd256);
`else
    pop(8'd100);
    check("sp_wrap_pop", {16'd0, sp}, 32'd257);
    load(16'd256);
`endif
    idle(3);

    // req together with PUSH: only the push happens
    wr(16'h0005, 8'h11);
    req = 1'b1; we = 1'b1; addr = 16'h0005; wdata = 8'h77; sp_op = 2'b01;
    #1;
    check("ready_during_push", {31'd0, ready}, 32'd0);
    tick();
    req = 1'b0; we = 1'b0; sp_op = 2'b00;
    check("sp_push_only", {16'd0, sp}, 32'd255);
    rd(16'h0005, 8'h11, 1'b0);
    rd(16'h00FF, 8'h77, 1'b0);
    idle(3);

    // reset with a read in flight: no rvalid afterwards, sp back to top
    load(16'd100);
    check("sp_load", {16'd0, sp}, 32'd100);
    req = 1'b1; we = 1'b0; addr = 16'h0000;
    tick();
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rvalid_in_reset", {31'd0, rvalid}, 32'd0);
    idle(2);
    check("sp_after_reset", {16'd0, sp}, 32'd256);
    rst_n = 1'b1;
    idle(4);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
